// File: rtl/rtc_i2c_poller.sv
// I2C master that burst-reads NREGS consecutive MCP79410 RTCC registers on request
// and presents them atomically on time_data.
module rtc_i2c_poller #(
  parameter int unsigned CLKDIV    = 4,
  parameter logic [6:0]  DEV_ADDR  = 7'h6F,
  parameter logic [7:0]  START_REG = 8'h00,
  parameter int unsigned NREGS     = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               ack_err,
  output logic [8*NREGS-1:0] time_data,
  input  logic               scl_in,
  output logic               scl_oe,
  input  logic               sda_in,
  output logic               sda_oe
);

  localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WR_ADDR, S_WR_REG, S_RSTART, S_RD_ADDR, S_RD_DATA, S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic [1:0]         qtr_q, qtr_d;
  logic [3:0]         bit_q, bit_d;
  logic [2:0]         byte_q, byte_d;
  logic [7:0]         rx_q, rx_d;
  logic [8*NREGS-1:0] shadow_q, shadow_d;
  logic [8*NREGS-1:0] time_q, time_d;
  logic               ack_err_q, ack_err_d;
  logic               done_q, done_d;
  logic               scl_oe_q, scl_oe_d;
  logic               sda_oe_q, sda_oe_d;

  logic data_st, stall, tick;

  // Pad drive {scl_oe, sda_oe} for a given sequencer position; applied to the
  // next-state values so the registered pad outputs line up with the quarter.
  function automatic logic [1:0] bus_drive(state_t st, logic [1:0] q, logic [3:0] b,
                                           logic [2:0] by);
    logic [7:0] tx;
    logic       bit_sda;
    tx = '0;
    case (st)
      S_WR_ADDR: tx = {DEV_ADDR, 1'b0};
      S_WR_REG:  tx = START_REG;
      S_RD_ADDR: tx = {DEV_ADDR, 1'b1};
      default:   tx = '0;
    endcase
    if (st == S_RD_DATA) bit_sda = (b == 4'd8) && (by != 3'(NREGS - 1));
    else if (b == 4'd8)  bit_sda = 1'b0;
    else                 bit_sda = !tx[3'd7 - b[2:0]];
    case (st)
      S_IDLE:   bus_drive = 2'b00;
      S_START:  bus_drive = {1'b0, q[1]};
      S_RSTART: bus_drive = {q == 2'd0, q[1]};
      S_STOP:   bus_drive = {q == 2'd0, q != 2'd3};
      default:  bus_drive = {!q[1], bit_sda};
    endcase
  endfunction

  assign data_st = state_q inside {S_WR_ADDR, S_WR_REG, S_RD_ADDR, S_RD_DATA};
  assign stall   = data_st && (qtr_q == 2'd2) && !scl_in;
  assign tick    = (state_q != S_IDLE) && (div_q == DW'(CLKDIV - 1)) && !stall;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    rx_d      = rx_q;
    shadow_d  = shadow_q;
    time_d    = time_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;

    if (state_q == S_IDLE) begin
      if (start && !done_q) begin
        state_d   = S_START;
        div_d     = '0;
        qtr_d     = '0;
        bit_d     = '0;
        byte_d    = '0;
        ack_err_d = 1'b0;
      end
    end else begin
      if (!stall) div_d = tick ? '0 : div_q + 1'b1;
      if (tick)   qtr_d = qtr_q + 2'd1;

      // SDA is sampled on the last cycle of q2 (after any stretch has ended)
      if (data_st && tick && (qtr_q == 2'd2)) begin
        if (bit_q == 4'd8) begin
          if (state_q != S_RD_DATA && sda_in) ack_err_d = 1'b1;
        end else if (state_q == S_RD_DATA) begin
          rx_d = {rx_q[6:0], sda_in};
          if (bit_q == 4'd7) shadow_d[{byte_q, 3'b000} +: 8] = {rx_q[6:0], sda_in};
        end
      end

      if (tick && (qtr_q == 2'd3)) begin
        case (state_q)
          S_START:  begin state_d = S_WR_ADDR; bit_d = '0; end
          S_RSTART: begin state_d = S_RD_ADDR; bit_d = '0; end
          S_STOP: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (!ack_err_q) time_d = shadow_q;
          end
          default: begin
            if (bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
            end else begin
              bit_d = '0;
              if (ack_err_q) begin
                state_d = S_STOP;
              end else begin
                case (state_q)
                  S_WR_ADDR: state_d = S_WR_REG;
                  S_WR_REG:  state_d = S_RSTART;
                  S_RD_ADDR: begin state_d = S_RD_DATA; byte_d = '0; end
                  default: begin
                    if (byte_q == 3'(NREGS - 1)) state_d = S_STOP;
                    else                         byte_d  = byte_q + 3'd1;
                  end
                endcase
              end
            end
          end
        endcase
      end
    end

    {scl_oe_d, sda_oe_d} = bus_drive(state_d, qtr_d, bit_d, byte_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      rx_q      <= '0;
      shadow_q  <= '0;
      time_q    <= '0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      rx_q      <= rx_d;
      shadow_q  <= shadow_d;
      time_q    <= time_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign ack_err   = ack_err_q;
  assign time_data = time_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;

endmodule

// File: tb/tb_rtc_i2c_poller.sv
// Bench for rtc_i2c_poller: open-drain bus with a behavioural MCP79410 slave model.
module tb_rtc_i2c_poller;

  localparam int unsigned CLKDIV    = 4;
  localparam int unsigned NREGS     = 7;
  localparam int          STRETCH_K = 2 * CLKDIV + 40;

  logic               clk = 1'b0;
  logic               reset, start;
  logic               busy, done, ack_err;
  logic [8*NREGS-1:0] time_data;
  logic               scl_oe, sda_oe;
  logic               scl_bus, sda_bus;

  // slave model controls and observations
  logic       slv_clr, present, stretch_en;
  logic [7:0] data_base;
  logic       sda_low, scl_p, sda_p, oe_p, active, rd_mode, nacked;
  int         hold_cnt, sbit, sbyte, stops, nrx, rises;
  logic [7:0] sh, rb, macks;
  logic [7:0] rxl [0:3];

  int tests_run    = 0;
  int tests_failed = 0;

  assign scl_bus = !(scl_oe || (hold_cnt != 0));
  assign sda_bus = !(sda_oe || sda_low);

  always #5 clk = ~clk;

  rtc_i2c_poller #(
    .CLKDIV   (CLKDIV),
    .DEV_ADDR (7'h6F),
    .START_REG(8'h00),
    .NREGS    (NREGS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .time_data(time_data),
    .scl_in   (scl_bus),
    .scl_oe   (scl_oe),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe)
  );

  // Slave: ACKs its address and pointer, returns data_base+i for register i,
  // and optionally stretches SCL on the third bit of the first data byte.
  always @(negedge clk) begin
    if (slv_clr) begin
      sda_low = 1'b0; hold_cnt = 0; active = 1'b0; sbit = 0; sbyte = 0;
      rd_mode = 1'b0; nacked = 1'b0; stops = 0; nrx = 0; macks = '0; rises = 0;
      scl_p = 1'b1; sda_p = 1'b1; oe_p = 1'b0; sh = '0;
    end else begin
      if (hold_cnt != 0) hold_cnt--;
      if (scl_oe && !oe_p) begin
        rises++;
        if (stretch_en && rises == 31) hold_cnt = STRETCH_K;
      end
      oe_p = scl_oe;
      if (scl_p && scl_bus && sda_p && !sda_bus) begin
        active = 1'b1; sbit = 0; sbyte = 0; rd_mode = 1'b0; nacked = 1'b0; sda_low = 1'b0;
      end else if (scl_p && scl_bus && !sda_p && sda_bus) begin
        stops++; active = 1'b0; sda_low = 1'b0;
      end else if (active && !scl_p && scl_bus) begin
        if (sbit < 8) sh = {sh[6:0], sda_bus};
        else if (rd_mode && sbyte > 0) begin
          macks[sbyte-1] = sda_bus;
          if (sda_bus) nacked = 1'b1;
        end
        sbit++;
      end else if (active && scl_p && !scl_bus) begin
        if (sbit == 9) begin sbit = 0; sbyte++; end
        if (sbit == 8) begin
          if (!rd_mode || sbyte == 0) begin
            if (nrx < 4) rxl[nrx] = sh;
            nrx++;
            sda_low = present && (sbyte != 0 || sh[7:1] == 7'h6F);
            if (sbyte == 0) rd_mode = sh[0];
          end else sda_low = 1'b0;
        end else if (rd_mode && sbyte >= 1 && sbyte <= NREGS && !nacked) begin
          rb      = data_base + 8'(sbyte - 1);
          sda_low = !rb[7-sbit];
        end else sda_low = 1'b0;
      end
      scl_p = scl_bus;
      sda_p = sda_bus;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_slave();
    @(posedge clk); slv_clr = 1'b1;
    @(posedge clk); slv_clr = 1'b0;
    @(negedge clk);
  endtask

  // Pulse start; count busy cycles (bounded); optionally re-pulse start while busy.
  task automatic run_txn(input int extra_at, output int len, output logic got_done);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    len   = 0;
    while (busy && len < 4000) begin
      len++;
      start = (len == extra_at);
      @(negedge clk);
    end
    start    = 1'b0;
    got_done = done;
  endtask

  int   len, n, dones;
  logic gd;

  initial begin
    reset = 1'b1; start = 1'b0; slv_clr = 1'b1; present = 1'b1;
    stretch_en = 1'b0; data_base = 8'h10;

    // 1: reset
    repeat (3) @(negedge clk);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_time", time_data, 0);
    reset = 1'b0;
    clr_slave();

    // 2: nominal read
    run_txn(0, len, gd);
    check("nom_len", len, 1488);
    check("nom_done", gd, 1);
    check("nom_time", time_data, 56'h16151413121110);
    check("nom_ack_err", ack_err, 0);
    check("nom_wr_addr", rxl[0], 8'hDE);
    check("nom_pointer", rxl[1], 8'h00);
    check("nom_rd_addr", rxl[2], 8'hDF);
    check("nom_macks", macks, 8'h40);
    check("nom_stops", stops, 1);
    @(negedge clk);
    check("nom_done_1cyc", done, 0);

    // 3: address NACK
    present = 1'b0;
    clr_slave();
    run_txn(0, len, gd);
    check("nack_len", len, 176);
    check("nack_done", gd, 1);
    check("nack_ack_err", ack_err, 1);
    check("nack_time", time_data, 56'h16151413121110);
    check("nack_stops", stops, 1);
    repeat (5) @(negedge clk);
    check("nack_err_held", ack_err, 1);

    // 4: clock stretch on first read byte
    present = 1'b1; stretch_en = 1'b1; data_base = 8'h30;
    clr_slave();
    run_txn(0, len, gd);
    check("str_len", len, 1528);
    check("str_done", gd, 1);
    check("str_time", time_data, 56'h36353433323130);
    check("str_ack_err", ack_err, 0);
    stretch_en = 1'b0; data_base = 8'h10;

    // 5: start while busy ignored, start in done cycle ignored
    clr_slave();
    run_txn(100, len, gd);
    check("busy_len", len, 1488);
    check("busy_stops", stops, 1);
    check("busy_done", gd, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("donecyc_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("donecyc_busy_later", busy, 0);

    // 6: reset during RD_DATA byte 2 (start held with reset must be ignored)
    data_base = 8'h50;
    clr_slave();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(rd_mode && sbyte == 3) && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check("mid_reached", (rd_mode && sbyte == 3), 1);
    check("mid_busy_before", busy, 1);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("mid_scl_oe", scl_oe, 0);
    check("mid_sda_oe", sda_oe, 0);
    check("mid_busy", busy, 0);
    check("mid_time", time_data, 0);
    clr_slave();
    dones = 0;
    repeat (60) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("mid_no_done", dones, 0);
    check("mid_idle", busy, 0);
    run_txn(0, len, gd);
    check("post_len", len, 1488);
    check("post_done", gd, 1);
    check("post_time", time_data, 56'h56555453525150);
    check("post_ack_err", ack_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
